// File: rtl/delay_arb_pkg.sv
// Shared types and the round-robin scan for the delay-unit arbiter.
// The default sizes here are the build configuration; the top's parameters default to them.
package delay_arb_pkg;

    localparam int N_REQ_DEF           = 2;
    localparam int DATA_WIDTH_DEF      = 5;
    localparam int MAX_OUTSTANDING_DEF = 4;

    localparam int ID_WIDTH = (N_REQ_DEF > 1) ? $clog2(N_REQ_DEF) : 1;

    typedef logic [ID_WIDTH-1:0] req_id_t;

    // First valid lane at or after ptr, wrapping; returns ptr when nothing is valid.
    function automatic req_id_t rr_pick(input logic [N_REQ_DEF-1:0] valid, input req_id_t ptr);
        req_id_t pick;
        logic    found;
        int      idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ_DEF; i++) begin
            idx = (int'(ptr) + i) % N_REQ_DEF;
            if (!found && valid[idx]) begin
                pick  = req_id_t'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/delay_arb_id_fifo.sv
// In-order FIFO of requester IDs for requests currently inside the delay unit.
// Push and pop may both happen in one cycle; count stays unchanged then.
module delay_arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/delay_unit_arbiter.sv
// Round-robin sharing of one in-order delay unit among N_REQ requesters,
// with an ID FIFO steering each response back to the lane that issued it.
module delay_unit_arbiter
    import delay_arb_pkg::*;
#(
    parameter int N_REQ           = N_REQ_DEF,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                                CLK,
    input  logic                                ASYNCRESET,
    input  logic [N_REQ*DATA_WIDTH-1:0]         REQ_data,
    input  logic [N_REQ-1:0]                    REQ_valid,
    output logic [N_REQ-1:0]                    REQ_ready,
    output logic [DATA_WIDTH-1:0]               RSP_data,
    output logic [N_REQ-1:0]                    RSP_valid,
    input  logic [N_REQ-1:0]                    RSP_ready,
    output logic [DATA_WIDTH-1:0]               DU_IN_data,
    output logic                                DU_IN_valid,
    input  logic                                DU_IN_ready,
    input  logic [DATA_WIDTH-1:0]               DU_OUT_data,
    input  logic                                DU_OUT_valid,
    output logic                                DU_OUT_ready,
    output logic [$clog2(MAX_OUTSTANDING):0]    OUTSTANDING,
    output logic                                ERR
);

    req_id_t rr_ptr;
    req_id_t lock_id;
    req_id_t grant;
    req_id_t head;
    logic    lock;
    logic    full;
    logic    empty;
    logic    accept;
    logic    pop;
    logic    err;

    // A stalled offer stays locked to its lane so data cannot change under backpressure.
    assign grant = lock ? lock_id : rr_pick(REQ_valid, rr_ptr);

    // Request outputs are forced low while reset is asserted, not just after the next edge.
    always_comb begin
        DU_IN_valid      = REQ_valid[grant] & ~full & ~ASYNCRESET;
        DU_IN_data       = REQ_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        REQ_ready        = '0;
        REQ_ready[grant] = DU_IN_ready & ~full & ~ASYNCRESET;
    end

    assign accept = DU_IN_valid & DU_IN_ready;

    always_comb begin
        RSP_valid       = '0;
        RSP_valid[head] = DU_OUT_valid & ~empty;
        RSP_data        = DU_OUT_data;
        DU_OUT_ready    = ~empty & RSP_ready[head];
    end

    assign pop = DU_OUT_valid & DU_OUT_ready;
    assign ERR = err;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            rr_ptr  <= '0;
            lock    <= 1'b0;
            lock_id <= '0;
            err     <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr <= req_id_t'((int'(grant) + 1) % N_REQ);
                lock   <= 1'b0;
            end else if (DU_IN_valid) begin
                lock    <= 1'b1;
                lock_id <= grant;
            end
            if (DU_OUT_valid && empty) begin
                err <= 1'b1;
            end
        end
    end

    delay_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_WIDTH)
    ) u_id_fifo (
        .clk   (CLK),
        .rst   (ASYNCRESET),
        .push  (accept),
        .pop   (pop),
        .din   (grant),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (OUTSTANDING)
    );

endmodule

// File: tb/tb_delay_unit_arbiter.sv
// Bench for delay_unit_arbiter: requester queues, a 3-cycle echo delay unit model,
// and an in-order scoreboard of accepted requests against returned responses.
module tb_delay_unit_arbiter;

    logic        CLK;
    logic        ASYNCRESET;
    logic [9:0]  REQ_data;
    logic [1:0]  REQ_valid;
    logic [1:0]  REQ_ready;
    logic [4:0]  RSP_data;
    logic [1:0]  RSP_valid;
    logic [1:0]  RSP_ready;
    logic [4:0]  DU_IN_data;
    logic        DU_IN_valid;
    logic        DU_IN_ready;
    logic [4:0]  DU_OUT_data;
    logic        DU_OUT_valid;
    logic        DU_OUT_ready;
    logic [2:0]  OUTSTANDING;
    logic        ERR;

    delay_unit_arbiter dut (
        .CLK          (CLK),
        .ASYNCRESET   (ASYNCRESET),
        .REQ_data     (REQ_data),
        .REQ_valid    (REQ_valid),
        .REQ_ready    (REQ_ready),
        .RSP_data     (RSP_data),
        .RSP_valid    (RSP_valid),
        .RSP_ready    (RSP_ready),
        .DU_IN_data   (DU_IN_data),
        .DU_IN_valid  (DU_IN_valid),
        .DU_IN_ready  (DU_IN_ready),
        .DU_OUT_data  (DU_OUT_data),
        .DU_OUT_valid (DU_OUT_valid),
        .DU_OUT_ready (DU_OUT_ready),
        .OUTSTANDING  (OUTSTANDING),
        .ERR          (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       lane;
        logic [4:0] data;
    } exp_t;

    typedef struct {
        logic [4:0] data;
        int         due;
    } du_t;

    logic [4:0] lq0[$];
    logic [4:0] lq1[$];
    exp_t       exp_q[$];
    du_t        du_q[$];
    logic       exp_lane_q[$];

    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    logic du_in_rdy  = 1'b1;
    logic du_hold    = 1'b0;
    logic du_spur    = 1'b0;
    logic [1:0] rsp_rdy = 2'b11;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic drive();
        REQ_valid    = {lq1.size() > 0, lq0.size() > 0};
        REQ_data     = {(lq1.size() > 0) ? lq1[0] : 5'd0, (lq0.size() > 0) ? lq0[0] : 5'd0};
        DU_IN_ready  = du_in_rdy;
        RSP_ready    = rsp_rdy;
        DU_OUT_valid = du_spur || (!du_hold && du_q.size() > 0 && du_q[0].due <= cyc);
        DU_OUT_data  = (du_q.size() > 0) ? du_q[0].data : 5'd0;
    endtask

    task automatic sample();
        logic       lane;
        logic [4:0] want;
        exp_t       e;
        if (DU_IN_valid && DU_IN_ready) begin
            lane = REQ_ready[1];
            chk("req_ready_onehot", 32'($countones(REQ_ready)), 32'd1);
            chk("accept_lane_valid", 32'(REQ_valid[lane]), 32'd1);
            if ((lane ? lq1.size() : lq0.size()) > 0) begin
                want = lane ? lq1.pop_front() : lq0.pop_front();
                chk("du_in_data", 32'(DU_IN_data), 32'(want));
                if (exp_lane_q.size() > 0) chk("grant_order", 32'(lane), 32'(exp_lane_q.pop_front()));
                exp_q.push_back('{lane: lane, data: want});
                du_q.push_back('{data: want, due: cyc + 3});
            end
        end
        if (DU_OUT_valid && DU_OUT_ready) begin
            chk("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rsp_valid", 32'(RSP_valid), e.lane ? 32'd2 : 32'd1);
                chk("rsp_data", 32'(RSP_data), 32'(e.data));
            end
            if (du_q.size() > 0) void'(du_q.pop_front());
        end
    endtask

    task automatic step();
        drive();
        @(negedge CLK);
        sample();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((lq0.size() + lq1.size() + exp_q.size()) > 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_left", 32'(lq0.size() + lq1.size() + exp_q.size()), 32'd0);
        chk("drain_outstanding", 32'(OUTSTANDING), 32'd0);
    endtask

    task automatic apply_reset();
        ASYNCRESET = 1'b1;
        lq0.delete(); lq1.delete(); exp_q.delete(); du_q.delete(); exp_lane_q.delete();
        drive();
        @(posedge CLK);
        #1;
        ASYNCRESET = 1'b0;
    endtask

    initial begin
        ASYNCRESET = 1'b1;
        drive();
        #1;
        chk("rst_outstanding", 32'(OUTSTANDING), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_du_in_valid", 32'(DU_IN_valid), 32'd0);
        chk("rst_req_ready", 32'(REQ_ready), 32'd0);
        chk("rst_rsp_valid", 32'(RSP_valid), 32'd0);
        chk("rst_du_out_ready", 32'(DU_OUT_ready), 32'd0);
        @(posedge CLK);
        #1;
        ASYNCRESET = 1'b0;

        // single request, 3-cycle echo back to lane 0
        lq0.push_back(5'h0A);
        drive(); #1;
        chk("t1_du_in_valid", 32'(DU_IN_valid), 32'd1);
        chk("t1_du_in_data", 32'(DU_IN_data), 32'h0A);
        chk("t1_req_ready", 32'(REQ_ready), 32'd1);
        step();
        chk("t1_outstanding", 32'(OUTSTANDING), 32'd1);
        step();
        step();
        drive(); #1;
        chk("t1_rsp_valid", 32'(RSP_valid), 32'd1);
        chk("t1_rsp_data", 32'(RSP_data), 32'h0A);
        step();
        chk("t1_outstanding_end", 32'(OUTSTANDING), 32'd0);

        // both lanes busy: strict alternation from a fresh pointer
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            lq0.push_back(5'h10 + 5'(i));
            lq1.push_back(5'h18 + 5'(i));
            exp_lane_q.push_back(1'b0);
            exp_lane_q.push_back(1'b1);
        end
        drain(40);
        chk("t2_order_consumed", 32'(exp_lane_q.size()), 32'd0);

        // fill to MAX_OUTSTANDING with the delay unit silent
        du_hold = 1'b1;
        for (int i = 0; i < 5; i++) lq0.push_back(5'h03 + 5'(i));
        for (int i = 0; i < 4; i++) step();
        chk("t3_outstanding_full", 32'(OUTSTANDING), 32'd4);
        drive(); #1;
        chk("t3_full_du_in_valid", 32'(DU_IN_valid), 32'd0);
        chk("t3_full_req_ready", 32'(REQ_ready), 32'd0);
        step();
        du_hold = 1'b0;
        drive(); #1;
        chk("t3_pop_cycle_no_push", 32'(DU_IN_valid), 32'd0);
        chk("t3_pop_du_out_ready", 32'(DU_OUT_ready), 32'd1);
        step();
        chk("t3_outstanding_after_pop", 32'(OUTSTANDING), 32'd3);
        drive(); #1;
        chk("t3_push_resumes", 32'(DU_IN_valid), 32'd1);
        drain(40);

        // lock: lane 0 stalled, lane 1 arrives (pointer now favours lane 1)
        du_in_rdy = 1'b0;
        lq0.push_back(5'h05);
        step();
        lq1.push_back(5'h15);
        drive(); #1;
        chk("t4_lock_data", 32'(DU_IN_data), 32'h05);
        chk("t4_lock_valid", 32'(DU_IN_valid), 32'd1);
        chk("t4_lock_req_ready", 32'(REQ_ready), 32'd0);
        step();
        step();
        du_in_rdy = 1'b1;
        drive(); #1;
        chk("t4_held_data", 32'(DU_IN_data), 32'h05);
        chk("t4_accept_ready", 32'(REQ_ready), 32'd1);
        step();
        drive(); #1;
        chk("t4_next_data", 32'(DU_IN_data), 32'h15);
        chk("t4_next_ready", 32'(REQ_ready), 32'd2);
        drain(40);

        // response backpressure, then push and pop in the same cycle
        lq0.push_back(5'h07);
        step();
        step();
        step();
        rsp_rdy = 2'b00;
        drive(); #1;
        chk("t5_rsp_valid_held", 32'(RSP_valid), 32'd1);
        chk("t5_du_out_ready", 32'(DU_OUT_ready), 32'd0);
        step();
        chk("t5_count_held", 32'(OUTSTANDING), 32'd1);
        rsp_rdy = 2'b11;
        lq1.push_back(5'h17);
        drive(); #1;
        chk("t5_both_push", 32'(DU_IN_valid & DU_IN_ready), 32'd1);
        chk("t5_both_pop", 32'(DU_OUT_valid & DU_OUT_ready), 32'd1);
        step();
        chk("t5_count_push_pop", 32'(OUTSTANDING), 32'd1);
        drain(40);

        // spurious delay-unit output while empty
        du_spur = 1'b1;
        drive(); #1;
        chk("t6_spur_rsp_valid", 32'(RSP_valid), 32'd0);
        chk("t6_spur_du_out_ready", 32'(DU_OUT_ready), 32'd0);
        step();
        du_spur = 1'b0;
        chk("t6_err_set", 32'(ERR), 32'd1);
        step();
        chk("t6_err_sticky", 32'(ERR), 32'd1);

        // reset in the middle of a burst
        for (int i = 0; i < 3; i++) begin
            lq0.push_back(5'h08 + 5'(i));
            lq1.push_back(5'h1C + 5'(i));
        end
        step();
        step();
        step();
        drive();
        ASYNCRESET = 1'b1;
        #1;
        chk("t6_rst_du_in_valid", 32'(DU_IN_valid), 32'd0);
        chk("t6_rst_req_ready", 32'(REQ_ready), 32'd0);
        chk("t6_rst_rsp_valid", 32'(RSP_valid), 32'd0);
        chk("t6_rst_du_out_ready", 32'(DU_OUT_ready), 32'd0);
        chk("t6_rst_outstanding", 32'(OUTSTANDING), 32'd0);
        chk("t6_rst_err", 32'(ERR), 32'd0);
        lq0.delete(); lq1.delete(); exp_q.delete(); du_q.delete();
        drive();
        @(posedge CLK);
        #1;
        ASYNCRESET = 1'b0;
        lq1.push_back(5'h1F);
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
